gem_tx_frame_arbiter: RTL and testbench

Round-robin, frame-granular arbiter that shares the single GEM transmit path between `PORTS` 8-bit AXI-Stream requesters. It sits in front of the TX frame FIFO (`axis_fifo`, FRAME_FIFO mode) that feeds `gem_ext_fifo_tx`. A grant is held from the first beat to `tlast`, so frames are never interleaved. Frames longer than `MAX_FRAME_LEN` are truncated and marked bad via `tuser`, so the downstream frame FIFO discards them.

---
 rtl/gem_tx_frame_arbiter.sv | 163 ++++++++++++++++
 tb/tb_gem_tx_frame_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_tx_frame_arbiter.sv
// Round-robin, frame-granular AXI-Stream arbiter for the GEM TX path.
// Holds a grant from the first beat to tlast and truncates frames longer than MAX_FRAME_LEN.
module gem_tx_frame_arbiter #(
    parameter int PORTS         = 4,
    parameter int MAX_FRAME_LEN = 1536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS*8-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]   s_axis_tvalid,
    input  logic [PORTS-1:0]   s_axis_tlast,
    input  logic [PORTS-1:0]   s_axis_tuser,
    output logic [PORTS-1:0]   s_axis_tready,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    input  logic [PORTS-1:0]   port_enable,
    output logic [PORTS-1:0]   grant,
    output logic               frame_done,
    output logic               frame_oversize
);

    localparam int IW = $clog2(PORTS);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PORTS-1:0] r_grant;
    logic [IW-1:0]    r_last_grant;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;

    logic [PORTS-1:0] w_cand;
    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_idx;
    logic [7:0]       w_in_data;
    logic             w_in_valid;
    logic             w_in_last;
    logic             w_in_user;
    logic             w_beat;
    logic             w_trunc;

    // r_last_grant doubles as the index of the currently granted port.
    always_comb begin
        w_in_data  = s_axis_tdata[8*r_last_grant +: 8];
        w_in_valid = s_axis_tvalid[r_last_grant];
        w_in_last  = s_axis_tlast[r_last_grant];
        w_in_user  = s_axis_tuser[r_last_grant];
    end

    assign w_beat  = (r_state == PASS) && w_in_valid && m_axis_tready;
    assign w_trunc = (r_state == PASS) && (r_cnt == LAST_CNT) && !w_in_last;

    // Search starts one past the last winner so the port that just finished ranks lowest.
    always_comb begin
        w_cand  = s_axis_tvalid & port_enable;
        w_found = 1'b0;
        w_win   = r_last_grant;
        w_idx   = '0;
        for (int unsigned i = 1; i <= PORTS; i++) begin
            w_idx = IW'((32'(r_last_grant) + i) % 32'(PORTS));
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next = PASS;
                end
            end
            PASS: begin
                if (w_beat && w_in_last) begin
                    w_next = IDLE;
                end else if (w_beat && w_trunc) begin
                    w_next = DROP;
                end
            end
            DROP: begin
                if (w_in_valid && w_in_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= IW'(PORTS - 1);
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_beat && (w_in_last || w_trunc);
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_grant      <= PORTS'(1) << w_win;
                    r_last_grant <= w_win;
                    r_cnt        <= '0;
                end
            end else begin
                if (w_beat && (r_cnt != MAX_CNT)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_next == IDLE) begin
                    r_grant <= '0;
                end
            end
        end
    end

    always_comb begin
        s_axis_tready  = '0;
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        frame_oversize = 1'b0;
        case (r_state)
            PASS: begin
                m_axis_tdata                = w_in_data;
                m_axis_tvalid               = w_in_valid;
                m_axis_tlast                = w_in_last | w_trunc;
                m_axis_tuser                = w_in_user | w_trunc;
                s_axis_tready[r_last_grant] = m_axis_tready;
                frame_oversize              = w_beat && w_trunc;
            end
            DROP: begin
                s_axis_tready[r_last_grant] = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant      = r_grant;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gem_tx_frame_arbiter.sv
// Directed bench for gem_tx_frame_arbiter (PORTS=4, MAX_FRAME_LEN=64).
// Per-port frame sources drive the inputs; a monitor records every accepted output beat.
module tb_gem_tx_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tuser;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [3:0]  port_enable;
    logic [3:0]  grant;
    logic        frame_done;
    logic        frame_oversize;

    gem_tx_frame_arbiter #(
        .PORTS         (4),
        .MAX_FRAME_LEN (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .port_enable    (port_enable),
        .grant          (grant),
        .frame_done     (frame_done),
        .frame_oversize (frame_oversize)
    );

    always #5 clk = ~clk;

    int unsigned errs   = 0;
    int unsigned checks = 0;

    int unsigned src_len [4];
    int unsigned src_pos [4];
    int unsigned src_nfr [4];
    logic [7:0]  src_base[4];
    logic        src_bad [4];
    logic        rdy_rand;

    logic [7:0]  q_data[$];
    logic        q_last[$];
    logic        q_user[$];
    logic [3:0]  q_gnt [$];
    int unsigned q_cyc [$];
    int unsigned n_done, n_over, n_drop, n_busy, cyc;
    logic [3:0]  mon_grant, mon_sready;
    logic        mon_mvalid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int unsigned p, input int unsigned len, input int unsigned nfr,
                           input logic [7:0] base, input logic bad);
        src_len[p]  = len;
        src_pos[p]  = 0;
        src_nfr[p]  = nfr;
        src_base[p] = base;
        src_bad[p]  = bad;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_user.delete();
        q_gnt.delete();
        q_cyc.delete();
        n_done = 0;
        n_over = 0;
        n_drop = 0;
        n_busy = 0;
        cyc    = 0;
    endtask

    task automatic drive_src();
        for (int unsigned p = 0; p < 4; p++) begin
            s_axis_tvalid[p]       = (src_nfr[p] > 0);
            s_axis_tdata[8*p +: 8] = src_base[p] + 8'(src_pos[p]);
            s_axis_tlast[p]        = (src_pos[p] == src_len[p] - 1);
            s_axis_tuser[p]        = src_bad[p] && (src_pos[p] == src_len[p] - 1);
        end
    endtask

    // One clock: drive at posedge+1, sample at posedge+5, advance sources after the edge.
    task automatic cycle();
        logic [3:0] hs;
        drive_src();
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #4;
        mon_grant  = grant;
        mon_mvalid = m_axis_tvalid;
        mon_sready = s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_user.push_back(m_axis_tuser);
            q_gnt.push_back(grant);
            q_cyc.push_back(cyc);
        end
        if (frame_done) n_done++;
        if (frame_oversize) n_over++;
        if (grant != 4'b0000) n_busy++;
        hs = s_axis_tvalid & s_axis_tready;
        for (int unsigned p = 0; p < 4; p++) begin
            if (hs[p] && !m_axis_tvalid) n_drop++;
        end
        @(posedge clk);
        #1;
        for (int unsigned p = 0; p < 4; p++) begin
            if (hs[p]) begin
                src_pos[p]++;
                if (src_pos[p] == src_len[p]) begin
                    src_pos[p] = 0;
                    src_nfr[p]--;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int unsigned p = 0; p < 4; p++) set_src(p, 1, 0, 8'h00, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic scan(input logic [7:0] base, input logic [3:0] gnt, output int unsigned derr,
                        output int unsigned nlast, output int unsigned nuser);
        derr  = 0;
        nlast = 0;
        nuser = 0;
        for (int unsigned k = 0; k < q_data.size(); k++) begin
            if (q_data[k] !== base + 8'(k) || q_gnt[k] !== gnt) derr++;
            if (q_last[k]) nlast++;
            if (q_user[k]) nuser++;
        end
    endtask

    int unsigned derr, nlast, nuser, fi, ep, gap_err;

    initial begin
        rst           = 1'b1;
        rdy_rand      = 1'b0;
        port_enable   = 4'hF;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        for (int unsigned p = 0; p < 4; p++) set_src(p, 1, 0, 8'h00, 1'b0);
        @(posedge clk);
        #1;

        // Reset state
        cycle();
        cycle();
        chk("rst_grant", 32'(mon_grant), 32'h0);
        chk("rst_sready", 32'(mon_sready), 32'h0);
        chk("rst_mvalid", 32'(mon_mvalid), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_over", 32'(frame_oversize), 32'h0);
        rst = 1'b0;
        clear_mon();

        // Single port: port 1, 60 bytes
        set_src(1, 60, 1, 8'h10, 1'b0);
        for (int unsigned n = 0; n < 200 && n_done == 0; n++) cycle();
        cycle();
        scan(8'h10, 4'b0010, derr, nlast, nuser);
        chk("single_count", q_data.size(), 60);
        chk("single_data", derr, 0);
        chk("single_nlast", nlast, 1);
        chk("single_last_pos", 32'(q_last[59]), 1);
        chk("single_user", nuser, 0);
        chk("single_done", n_done, 1);
        chk("single_over", n_over, 0);
        chk("single_latency", q_cyc[0], 1);

        // Round-robin: all ports requesting 10-byte frames
        do_reset();
        for (int unsigned p = 0; p < 4; p++) set_src(p, 10, (p == 0) ? 2 : 1, 8'(8'h40 * p), 1'b0);
        nlast = 0;
        for (int unsigned n = 0; n < 200 && nlast < 5; n++) begin
            cycle();
            nlast = 0;
            foreach (q_last[k]) if (q_last[k]) nlast++;
        end
        chk("rr_count", q_data.size(), 50);
        derr    = 0;
        gap_err = 0;
        for (int unsigned k = 0; k < 50 && k < q_data.size(); k++) begin
            fi = k / 10;
            ep = (fi == 4) ? 0 : fi;
            if (q_data[k] !== src_base[ep] + 8'(k % 10)) derr++;
            if (q_last[k] !== ((k % 10) == 9)) derr++;
            if (q_gnt[k] !== 4'(1 << ep)) derr++;
        end
        for (int unsigned f = 0; f < 4; f++) begin
            if (q_cyc.size() > 10 * f + 10) begin
                if (q_cyc[10*f+10] - q_cyc[10*f+9] != 2) gap_err++;
            end else begin
                gap_err++;
            end
        end
        chk("rr_order_data", derr, 0);
        chk("rr_gap", gap_err, 0);
        for (int unsigned f = 0; f < 5; f++) begin
            ep = (f == 4) ? 0 : f;
            chk($sformatf("rr_grant_f%0d", f), 32'(q_gnt[10*f]), 32'(1 << ep));
        end

        // Oversize: port 2 sends 100 bytes with a 64-byte limit
        do_reset();
        set_src(2, 100, 1, 8'h00, 1'b0);
        for (int unsigned n = 0; n < 300 && src_nfr[2] != 0; n++) cycle();
        cycle();
        cycle();
        scan(8'h00, 4'b0100, derr, nlast, nuser);
        chk("over_count", q_data.size(), 64);
        chk("over_data", derr, 0);
        chk("over_last_pos", 32'(q_last[63]), 1);
        chk("over_user_pos", 32'(q_user[63]), 1);
        chk("over_nlast", nlast, 1);
        chk("over_nuser", nuser, 1);
        chk("over_pulse", n_over, 1);
        chk("over_done", n_done, 1);
        chk("over_dropped", n_drop, 36);
        chk("over_consumed", src_nfr[2], 0);
        chk("over_idle_after", 32'(mon_grant), 32'h0);

        // Exactly MAX_FRAME_LEN bytes is not oversize
        clear_mon();
        set_src(2, 64, 1, 8'h20, 1'b0);
        for (int unsigned n = 0; n < 200 && n_done == 0; n++) cycle();
        cycle();
        scan(8'h20, 4'b0100, derr, nlast, nuser);
        chk("max_count", q_data.size(), 64);
        chk("max_data", derr, 0);
        chk("max_last_pos", 32'(q_last[63]), 1);
        chk("max_user", nuser, 0);
        chk("max_over", n_over, 0);
        chk("max_done", n_done, 1);

        // Mask, mid-frame disable and random back-pressure
        clear_mon();
        port_enable = 4'b1011;
        set_src(2, 20, 1, 8'h80, 1'b0);
        for (int unsigned n = 0; n < 6; n++) cycle();
        chk("mask_nogrant", n_busy, 0);
        chk("mask_nobeat", q_data.size(), 0);
        rdy_rand    = 1'b1;
        port_enable = 4'hF;
        for (int unsigned n = 0; n < 100 && q_data.size() < 3; n++) cycle();
        port_enable = 4'b1011;
        for (int unsigned n = 0; n < 400 && n_done == 0; n++) cycle();
        cycle();
        rdy_rand = 1'b0;
        scan(8'h80, 4'b0100, derr, nlast, nuser);
        chk("bp_count", q_data.size(), 20);
        chk("bp_data", derr, 0);
        chk("bp_last_pos", 32'(q_last[19]), 1);
        chk("bp_nlast", nlast, 1);
        chk("bp_done", n_done, 1);
        port_enable = 4'hF;

        // Reset mid-frame on port 3, then port 0 wins over port 3
        do_reset();
        set_src(3, 20, 1, 8'hC0, 1'b0);
        for (int unsigned n = 0; n < 50 && q_data.size() < 5; n++) cycle();
        chk("rstmid_progress", q_data.size(), 5);
        rst = 1'b1;
        cycle();
        cycle();
        chk("rstmid_grant", 32'(mon_grant), 32'h0);
        chk("rstmid_mvalid", 32'(mon_mvalid), 32'h0);
        chk("rstmid_sready", 32'(mon_sready), 32'h0);
        rst = 1'b0;
        set_src(0, 4, 1, 8'h50, 1'b0);
        set_src(3, 4, 1, 8'hC0, 1'b0);
        clear_mon();
        cycle();
        cycle();
        chk("rstmid_prio_grant", 32'(mon_grant), 32'h1);
        chk("rstmid_prio_data", 32'(q_data[0]), 32'h50);
        for (int unsigned n = 0; n < 100 && n_done < 2; n++) cycle();
        chk("rstmid_drain", n_done, 2);

        // Error pass-through: tuser on the last beat of port 0
        clear_mon();
        set_src(0, 8, 1, 8'h60, 1'b1);
        for (int unsigned n = 0; n < 100 && n_done == 0; n++) cycle();
        cycle();
        scan(8'h60, 4'b0001, derr, nlast, nuser);
        chk("err_count", q_data.size(), 8);
        chk("err_data", derr, 0);
        chk("err_user_last", 32'(q_user[7]), 1);
        chk("err_nuser", nuser, 1);
        chk("err_over", n_over, 0);
        chk("err_done", n_done, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
